// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-ported, variable-latency memory between the
//                instruction-fetch port and the load/store data port. Data has
//                priority; a starvation counter forces a fetch grant after
//                STARVE_MAX consecutive data grants with a fetch waiting. A
//                watchdog aborts any access whose ack does not arrive within
//                TIMEOUT cycles and raises a sticky error flag.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i        clock, rising edge
//    rst_i        asynchronous reset, active-low
//    i_req_i      fetch request (level, held until i_ready_o)
//    i_addr_i     fetch address
//    i_ready_o    one-cycle fetch completion pulse
//    i_rdata_o    fetched word, valid with i_ready_o
//    d_req_i      data request (level, held until d_ready_o)
//    d_we_i       1 = store, 0 = load
//    d_addr_i     data address
//    d_wdata_i    store data
//    d_ready_o    one-cycle data completion pulse
//    d_rdata_o    load data, valid with d_ready_o
//    mem_req_o    memory request, held until ack or abort
//    mem_we_o     memory write enable
//    mem_addr_o   memory address
//    mem_wdata_o  memory write data
//    mem_ack_i    memory completion pulse
//    mem_rdata_i  memory read data, valid with mem_ack_i
//    err_o        sticky watchdog-abort flag, cleared only by reset
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_ready_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ready_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);
  localparam logic [7:0] C_WD_LAST    = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic                owner_q;     // 1: data port owns the access, 0: fetch
  logic [3:0]          starve_q;
  logic [3:0]          starve_d;
  logic [7:0]          wd_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                i_ready_q;
  logic                d_ready_q;
  logic [DATA_W-1:0]   i_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                err_q;

  logic                grant_data;
  logic                grant_fetch;
  logic                finish;
  logic [DATA_W-1:0]   fill_data;

  // Arbitration and starvation bookkeeping; only acted upon in IDLE.
  always_comb begin
    grant_data  = d_req_i & (~i_req_i | (starve_q < C_STARVE_MAX));
    grant_fetch = i_req_i & ~grant_data;
    starve_d    = starve_q;
    if (grant_fetch) begin
      starve_d = '0;
    end else if (grant_data) begin
      if (!i_req_i) begin
        starve_d = '0;
      end else if (starve_q != C_STARVE_MAX) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  // An ack on the watchdog's final cycle takes precedence over the abort.
  always_comb begin
    finish    = mem_ack_i | (wd_q == C_WD_LAST);
    fill_data = mem_ack_i ? mem_rdata_i : '0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      starve_q    <= '0;
      wd_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_data || grant_fetch) begin
            owner_q     <= grant_data;
            starve_q    <= starve_d;
            wd_q        <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= grant_data & d_we_i;
            mem_addr_q  <= grant_data ? d_addr_i : i_addr_i;
            mem_wdata_q <= grant_data ? d_wdata_i : '0;
            state_q     <= S_BUSY;
          end
        end

        S_BUSY: begin
          if (finish) begin
            mem_req_q <= 1'b0;
            if (!mem_ack_i) begin
              err_q <= 1'b1;
            end
            // Stores leave the load-data register untouched.
            if (!mem_we_q) begin
              if (owner_q) begin
                d_rdata_q <= fill_data;
              end else begin
                i_rdata_q <= fill_data;
              end
            end
            if (owner_q) begin
              d_ready_q <= 1'b1;
            end else begin
              i_ready_q <= 1'b1;
            end
            state_q <= S_DONE;
          end else begin
            wd_q <= wd_q + 8'd1;
          end
        end

        S_DONE: begin
          // No arbitration here: the requester updates req on this edge.
          i_ready_q <= 1'b0;
          d_ready_q <= 1'b0;
          wd_q      <= '0;
          state_q   <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign i_ready_o   = i_ready_q;
  assign i_rdata_o   = i_rdata_q;
  assign d_ready_o   = d_ready_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;

endmodule
`default_nettype wire
